apb_master_bridge: RTL

- APB requester that sits directly upstream of the APB slaves (slave1 and a second slave) and drives their PSEL/PENABLE/PWRITE/padd/pwdata.
- Accepts single-beat transfer requests from a simple local command interface.
- Sequences the requests through the APB SETUP/ACCESS phases, honours per-slave PREADY, and returns read data, completion and error status.
- Address bit 7 selects the slave; a wait-state timeout guarantees termination.

---
 rtl/apb_master_bridge.sv | 117 +++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB requester: one local command -> SETUP + ACCESS on slave1/slave2 (addr bit 7), min 3 cycles req->tr_done.
// No upstream backpressure: tr_req is only taken in IDLE or at a completion edge; wait states bounded by TIMEOUT.
module apb_master_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             PCLK,
  input  logic             PRST,
  input  logic             tr_req,
  input  logic             tr_write,
  input  logic [7:0]       tr_addr,
  input  logic [7:0]       tr_wdata,
  output logic             tr_busy,
  output logic             tr_done,
  output logic             tr_err,
  output logic [7:0]       tr_rdata,
  output logic             PSEL1,
  output logic             PSEL2,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [7:0]       padd,
  output logic [7:0]       pwdata,
  input  logic [7:0]       prdata1,
  input  logic [7:0]       prdata2,
  input  logic             PREADY1,
  input  logic             PREADY2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t           state, state_n;
  logic [CNT_W-1:0] wait_cnt;
  logic [7:0]       addr_q, wdata_q, rdata_q;
  logic             write_q, done_q, err_q;

  logic             capture, complete, abort;
  logic             sel_ready;
  logic [7:0]       sel_rdata;

  assign sel_ready = addr_q[7] ? PREADY2 : PREADY1;
  assign sel_rdata = addr_q[7] ? prdata2 : prdata1;

  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (tr_req) begin
          capture = 1'b1;
          state_n = SETUP;
        end
      end
      SETUP: state_n = ACCESS;
      ACCESS: begin
        if (sel_ready) begin
          complete = 1'b1;
          // A pending request at the completion edge chains straight into SETUP.
          if (tr_req) begin
            capture = 1'b1;
            state_n = SETUP;
          end else begin
            state_n = IDLE;
          end
        end else if (wait_cnt == CNT_LAST) begin
          abort   = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state    <= IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= complete | abort;
      err_q  <= abort;
      if (capture) begin
        addr_q  <= tr_addr;
        wdata_q <= tr_wdata;
        write_q <= tr_write;
      end
      if (complete && !write_q)
        rdata_q <= sel_rdata;
      if (state == SETUP)
        wait_cnt <= '0;
      else if (state == ACCESS && !sel_ready && wait_cnt != CNT_MAX)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign tr_busy  = (state != IDLE);
  assign tr_done  = done_q;
  assign tr_err   = err_q;
  assign tr_rdata = rdata_q;
  assign PSEL1    = (state != IDLE) && !addr_q[7];
  assign PSEL2    = (state != IDLE) &&  addr_q[7];
  assign PENABLE  = (state == ACCESS);
  assign PWRITE   = write_q;
  assign padd     = addr_q;
  assign pwdata   = wdata_q;

endmodule
